// File: rtl/bf_phase_sequencer.sv
// Issuing-side sequencer for the Bellman-Ford AGU: phase pulses, flush steps,
// sweep counting and convergence / negative-cycle detection.
module bf_phase_sequencer #(
  parameter int NUM_COLUMNS = 16,
  parameter int PHASE_LEN   = 4,
  parameter int MAX_ITER    = 16,
  parameter int PW          = $clog2(PHASE_LEN),
  parameter int IW          = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst_global,
  input  logic          start,
  input  logic          abort,
  input  logic          iteration_done,
  input  logic          relax_update,
  output logic          read_enable_cu,
  output logic          write_enable_cu,
  output logic          pre_rollover_phase_counter,
  output logic          rollover_phase_counter,
  output logic [PW-1:0] phase_count,
  output logic [IW-1:0] iteration_count,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic          neg_cycle
);

  localparam int FW = $clog2(NUM_COLUMNS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [IW-1:0] iter_q;
  logic [FW-1:0] flushCnt_q;
  logic          updFlag_q;
  logic          readAhead_q;
  logic          done_q;
  logic          converged_q;
  logic          negCycle_q;

  logic          inRun;
  logic          inFlush;
  logic          preRoll;
  logic          roll;
  logic          sweepEnd;
  logic          flushExit;
  logic          updFlag_d;
  logic          readAhead_d;
  logic [IW-1:0] iter_d;
  logic [PW-1:0] phase_d;

  assign inRun    = (state_q == RUN);
  assign inFlush  = (state_q == FLUSH);
  assign preRoll  = inRun && (phase_q == PW'(PHASE_LEN - 2));
  assign roll     = inRun && (phase_q == PW'(PHASE_LEN - 1));
  assign sweepEnd = roll && iteration_done;

  assign updFlag_d = updFlag_q | relax_update;
  assign iter_d    = iter_q + IW'(1);
  assign phase_d   = (phase_q == PW'(PHASE_LEN - 1)) ? '0 : phase_q + PW'(1);

  // Read address is one column ahead between the pre-rollover and rollover steps.
  assign readAhead_d = preRoll ? 1'b1 :
                       (roll || inFlush) ? 1'b0 : readAhead_q;

  // The write address reaches the last column within NUM_COLUMNS flush steps;
  // the counter only bounds FLUSH should iteration_done never arrive.
  assign flushExit = iteration_done || (flushCnt_q == FW'(NUM_COLUMNS - 1));

  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      iter_q      <= '0;
      flushCnt_q  <= '0;
      updFlag_q   <= 1'b0;
      readAhead_q <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      negCycle_q  <= 1'b0;
    end else begin
      readAhead_q <= readAhead_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RUN;
            phase_q     <= '0;
            iter_q      <= '0;
            updFlag_q   <= 1'b0;
            readAhead_q <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            negCycle_q  <= 1'b0;
          end
        end
        RUN: begin
          if (sweepEnd) begin
            iter_q    <= iter_d;
            phase_q   <= '0;
            updFlag_q <= 1'b0;
            if (abort) begin
              state_q <= IDLE;
            end else if (!updFlag_d) begin
              converged_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else if (iter_d == IW'(MAX_ITER)) begin
              negCycle_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end
          end else if (abort) begin
            flushCnt_q <= '0;
            state_q    <= FLUSH;
          end else begin
            phase_q   <= phase_d;
            updFlag_q <= updFlag_d;
          end
        end
        FLUSH: begin
          flushCnt_q <= flushCnt_q + FW'(1);
          if (flushExit) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_enable_cu             = inFlush && !readAhead_q && !iteration_done;
  assign write_enable_cu            = inFlush;
  assign pre_rollover_phase_counter = preRoll;
  assign rollover_phase_counter     = roll;
  assign phase_count                = phase_q;
  assign iteration_count            = iter_q;
  assign busy                       = inRun || inFlush;
  assign done                       = done_q;
  assign converged                  = converged_q;
  assign neg_cycle                  = negCycle_q;

endmodule
